uart_tx_fifo: RTL and testbench

- Transmit buffer between the CPU bus decode and the existing `uart_tx` serialiser.
- Accepts bytes from CPU writes to the UART address at bus speed and stores up to DEPTH of them.
- Drains them into `uart_tx` one at a time, whenever the serialiser reports empty.
- Lets firmware queue a whole string without stalling the core for each of the 2604-clock bit times.

---
 rtl/uart_tx_fifo_pkg.sv | 13 +
 rtl/uart_tx_fifo_sync_fifo.sv | 78 +++++++
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 tb/tb_uart_tx_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: drain FSM encoding and the serial bit-time constant
// used by uart_rx/uart_tx alongside this buffer.
package uart_tx_fifo_pkg;

    localparam int CLKS_PER_BIT = 32'd2604;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic synchronous FIFO: storage array, wrapping pointers and a registered
// occupancy count with full/empty flags derived from it.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             wr_acc_s;
    logic             rd_acc_s;

    // A write into a full FIFO or a read from an empty one is simply ignored.
    assign wr_acc_s = wr_en && !full_r;
    assign rd_acc_s = rd_en && !empty_r;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, count and flags; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            empty_r <= (count_nxt_s == (AW+1)'(0));
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer between CPU writes and the uart_tx serialiser; drains
// one byte per uart_tx empty indication via a three-state load FSM.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [7:0]  din,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    input  logic        clr_ovf,
    output logic        tx_we,
    output logic [7:0]  tx_din,
    input  logic        tx_empty,
    output logic        idle
);

    drain_state_t state_r;
    logic         tx_we_r;
    logic [7:0]   tx_din_r;
    logic         overflow_r;
    logic         pop_s;
    logic [7:0]   rd_data_s;
    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic [AW:0]  fifo_count_s;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (we),
        .wr_data (din),
        .rd_en   (pop_s),
        .rd_data (rd_data_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign pop_s = (state_r == IDLE) && !fifo_empty_s && tx_empty;

    // Drain FSM: load one byte, drop the strobe, then a guard cycle while uart_tx updates empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            tx_we_r  <= 1'b0;
            tx_din_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        tx_we_r  <= 1'b1;
                        tx_din_r <= rd_data_s;
                        state_r  <= ISSUE;
                    end else begin
                        tx_we_r  <= 1'b0;
                    end
                end
                ISSUE: begin
                    tx_we_r <= 1'b0;
                    state_r <= HOLD;
                end
                HOLD: begin
                    tx_we_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    tx_we_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow; a write hitting a full FIFO beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (we && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end
    end

    assign full     = fifo_full_s;
    assign empty    = fifo_empty_s;
    assign count    = fifo_count_s;
    assign overflow = overflow_r;
    assign tx_we    = tx_we_r;
    assign tx_din   = tx_din_r;
    assign idle     = fifo_empty_s && tx_empty && (state_r == IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard checked on every tx_we.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [7:0] din;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf;
    logic       tx_we;
    logic [7:0] tx_din;
    logic       tx_empty;
    logic       idle;

    logic       model_en;
    logic       tx_empty_man;
    logic       model_empty;
    int         model_timer;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    always #20 clk = ~clk;

    assign tx_empty = model_en ? model_empty : tx_empty_man;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .din      (din),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx_we    (tx_we),
        .tx_din   (tx_din),
        .tx_empty (tx_empty),
        .idle     (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: empty falls the cycle after a load, rises 20 cycles later
    always @(posedge clk) begin
        if (!model_en) begin
            model_empty <= 1'b1;
            model_timer <= 0;
        end else if (tx_we) begin
            model_empty <= 1'b0;
            model_timer <= 20;
        end else if (model_timer != 0) begin
            model_timer <= model_timer - 1;
            if (model_timer == 1) model_empty <= 1'b1;
        end
    end

    // Scoreboard: every load strobe must carry the oldest outstanding byte
    always @(negedge clk) begin
        if (rst_n && tx_we) begin
            if (sb.size() == 0) begin
                check("tx_we_unexpected", 32'd1, 32'd0);
            end else begin
                check("tx_din_order", {24'd0, tx_din}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit expect_accept);
        we  = 1'b1;
        din = b;
        if (expect_accept) sb.push_back(b);
        @(negedge clk);
        we  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; din = 8'h00; clr_ovf = 1'b0;
        model_en = 1'b0; tx_empty_man = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_tx_we", {31'd0, tx_we}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);

        // Single byte latency
        write_byte(8'h41, 1'b1);
        check("single_cnt1", {27'd0, count}, 32'd1);
        check("single_we_early", {31'd0, tx_we}, 32'd0);
        @(negedge clk);
        check("single_we", {31'd0, tx_we}, 32'd1);
        check("single_din", {24'd0, tx_din}, 32'h41);
        check("single_cnt0", {27'd0, count}, 32'd0);
        @(negedge clk);
        check("single_we_fall", {31'd0, tx_we}, 32'd0);
        check("single_din_hold", {24'd0, tx_din}, 32'h41);
        repeat (3) @(negedge clk);

        // Burst into a stalled sink, then overflow handling
        tx_empty_man = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
        check("burst_full", {31'd0, full}, 32'd1);
        check("burst_count", {27'd0, count}, 32'd16);
        check("burst_no_we", {31'd0, tx_we}, 32'd0);
        write_byte(8'hFF, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count", {27'd0, count}, 32'd16);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);
        clr_ovf = 1'b1;
        write_byte(8'hEE, 1'b0);
        clr_ovf = 1'b0;
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;

        // Drain the full FIFO through the modelled serialiser while topping up
        model_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < 2000 && full; t++) @(negedge clk);
            write_byte(8'h10 + 8'(k), 1'b1);
        end
        for (int t = 0; t < 2000 && !(idle && sb.size() == 0); t++) @(negedge clk);
        check("wrap_drained", sb.size(), 32'd0);
        check("wrap_idle", {31'd0, idle}, 32'd1);
        check("wrap_no_ovf", {31'd0, overflow}, 32'd0);

        // Accepted write coincides with the pop edge
        model_en = 1'b0;
        tx_empty_man = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) write_byte(8'hA0 + 8'(i), 1'b1);
        check("simul_pre_cnt", {27'd0, count}, 32'd3);
        tx_empty_man = 1'b1;
        write_byte(8'hA3, 1'b1);
        tx_empty_man = 1'b0;
        check("simul_cnt", {27'd0, count}, 32'd3);
        check("simul_we", {31'd0, tx_we}, 32'd1);
        model_en = 1'b1;
        for (int t = 0; t < 1000 && !(idle && sb.size() == 0); t++) @(negedge clk);
        check("simul_drained", sb.size(), 32'd0);

        // Asynchronous reset while a load strobe is high
        model_en = 1'b0;
        tx_empty_man = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) write_byte(8'hB0 + 8'(i), 1'b1);
        tx_empty_man = 1'b1;
        @(negedge clk);
        check("arst_pre_we", {31'd0, tx_we}, 32'd1);
        check("arst_pre_cnt", {27'd0, count}, 32'd5);
        #5 rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, tx_we}, 32'd0);
        check("arst_cnt", {27'd0, count}, 32'd0);
        check("arst_empty", {31'd0, empty}, 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_quiet", {31'd0, tx_we}, 32'd0);
        check("arst_idle", {31'd0, idle}, 32'd1);
        write_byte(8'h5A, 1'b1);
        @(negedge clk);
        check("arst_resume_we", {31'd0, tx_we}, 32'd1);
        repeat (3) @(negedge clk);
        check("arst_resume_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
